// File: rtl/rift2_wb_bridge_if.sv
// Bus bundle between the Caravel Wishbone slave port and the rift2 core request/response channel.
// The bridge uses the slave modport; the Wishbone master / core model uses the master modport.
interface rift2_wb_bridge_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        err_irq;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output err_irq
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  err_irq
    );
endinterface

// File: rtl/rift2_wb_bridge.sv
// Wishbone classic slave turning each single access into one request/response on the rift2 core channel.
// Build macro RIFT2_WB_TIMEOUT_EN adds a REQ/WAIT watchdog with late-response drop.
module rift2_wb_bridge #(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFF00_0000,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] MISS_DATA   = 32'h0000_0000
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    rift2_wb_bridge_if.slave bus
);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic        acked_q, acked_d;
    logic        hit;
    logic        accept_hit;

`ifdef RIFT2_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            acked_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            data_q  <= data_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            acked_q <= acked_d;
        end
    end

`ifdef RIFT2_WB_TIMEOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        data_d  = data_q;
        err_d   = err_q;
        abort_d = abort_q;
        // acked_q blocks the IDLE cycle right after ACK, when the just-acked stb may still be high
        acked_d = (state_q == S_ACK);
        hit     = ((bus.wbs_adr_i & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
`ifdef RIFT2_WB_TIMEOUT_EN
        cnt_d      = '0;
        drop_d     = drop_q && !bus.rsp_valid;
        timeout    = 1'b0;
        accept_hit = !drop_q;
        if (state_q == S_REQ || state_q == S_WAIT) begin
            cnt_d   = cnt_q + CNT_W'(1);
            timeout = (cnt_q >= CNT_LAST);
        end
`else
        accept_hit = 1'b1;
`endif

        unique case (state_q)
            S_IDLE: begin
                err_d   = 1'b0;
                abort_d = 1'b0;
                if (bus.wbs_cyc_i && bus.wbs_stb_i && !acked_q) begin
                    if (!hit) begin
                        data_d  = MISS_DATA;
                        state_d = S_ACK;
                    end else if (accept_hit) begin
                        we_d    = bus.wbs_we_i;
                        addr_d  = bus.wbs_adr_i & ~ADDR_MASK;
                        wdata_d = bus.wbs_dat_i;
                        wstrb_d = bus.wbs_sel_i;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                abort_d = abort_q || !bus.wbs_cyc_i;
                if (bus.req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A master that dropped cyc still lets the core finish, it just never sees an ack
                abort_d = abort_q || !bus.wbs_cyc_i;
                if (bus.rsp_valid) begin
                    data_d  = bus.rsp_err ? ERR_DATA : (we_q ? 32'h0 : bus.rsp_rdata);
                    err_d   = bus.rsp_err;
                    state_d = abort_d ? S_IDLE : S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RIFT2_WB_TIMEOUT_EN
        // Timeout only wins when the handshake would not have advanced this cycle anyway
        if (timeout && state_d == state_q) begin
            data_d  = ERR_DATA;
            err_d   = 1'b1;
            state_d = abort_d ? S_IDLE : S_ACK;
            if (state_q == S_WAIT) drop_d = 1'b1;
        end
`endif
    end

    always_comb begin
        bus.wbs_ack_o = (state_q == S_ACK);
        bus.wbs_dat_o = (state_q == S_ACK) ? data_q : 32'h0;
        bus.req_valid = (state_q == S_REQ);
        bus.req_we    = we_q;
        bus.req_addr  = addr_q;
        bus.req_wdata = wdata_q;
        bus.req_wstrb = wstrb_q;
        bus.err_irq   = (state_q == S_ACK) && err_q;
    end
endmodule

// File: tb/tb_rift2_wb_bridge.sv
// Scoreboard bench for rift2_wb_bridge: expected acks are queued as accesses are driven and popped on ack.
// Define RIFT2_WB_TIMEOUT_EN at compile time to also exercise the watchdog path.
`timescale 1ns/1ps
module tb_rift2_wb_bridge;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] MASK    = 32'hFF00_0000;
    localparam logic [31:0] DEAD    = 32'hDEAD_BEEF;
    localparam int          TMO_CYC = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    exp_t expQ[$];

    rift2_wb_bridge_if bus();

    rift2_wb_bridge #(
        .ADDR_BASE  (BASE),
        .ADDR_MASK  (MASK),
        .TIMEOUT_CYC(TMO_CYC),
        .MISS_DATA  (32'h0000_0000)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Ack monitor: every ack must match the oldest queued expectation; no ack means dat_o and irq stay 0
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (!wb_rst_i) begin
            if (bus.wbs_ack_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(bus.wbs_ack_o), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack_data", bus.wbs_dat_o, e.data);
                    checkOutput("ack_irq", 32'(bus.err_irq), 32'(e.err));
                end
            end else begin
                checkOutput("idle_dat", bus.wbs_dat_o, 32'h0);
                checkOutput("idle_irq", 32'(bus.err_irq), 32'h0);
            end
        end
    end

    task automatic checkReq(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
        checkOutput("req_valid", 32'(bus.req_valid), 32'h1);
        checkOutput("req_addr", bus.req_addr, adr & ~MASK);
        checkOutput("req_we", 32'(bus.req_we), 32'(we));
        checkOutput("req_wdata", bus.req_wdata, dat);
        checkOutput("req_wstrb", 32'(bus.req_wstrb), 32'(sel));
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                 input logic [3:0] sel, input int readyDelay, input int rspDelay,
                                 input logic [31:0] rdata, input logic rspErr,
                                 input logic dropCyc, input logic holdStb);
        logic        hit;
        logic [31:0] expData;
        hit     = ((adr & MASK) == (BASE & MASK));
        expData = !hit ? 32'h0 : (rspErr ? DEAD : (we ? 32'h0 : rdata));
        @(negedge wb_clk_i);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        if (!dropCyc) expQ.push_back(exp_t'{data: expData, err: hit && rspErr});
        @(negedge wb_clk_i);
        if (hit) begin
            for (int i = 0; i < readyDelay; i++) begin
                checkReq(adr, we, dat, sel);
                @(negedge wb_clk_i);
            end
            checkReq(adr, we, dat, sel);
            bus.req_ready = 1'b1;
            @(negedge wb_clk_i);
            bus.req_ready = 1'b0;
            checkOutput("req_released", 32'(bus.req_valid), 32'h0);
            if (dropCyc) begin
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
            end
            repeat (rspDelay) @(negedge wb_clk_i);
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = rdata;
            bus.rsp_err   = rspErr;
            @(negedge wb_clk_i);
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = 32'h0;
            bus.rsp_err   = 1'b0;
        end else begin
            checkOutput("miss_no_req", 32'(bus.req_valid), 32'h0);
        end
        if (dropCyc) begin
            repeat (3) begin
                checkOutput("drop_no_ack", 32'(bus.wbs_ack_o), 32'h0);
                @(negedge wb_clk_i);
            end
        end else begin
            checkOutput("ack_latency", 32'(bus.wbs_ack_o), 32'h1);
            if (!holdStb) begin
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
            end
            @(negedge wb_clk_i);
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            checkOutput("ack_single", 32'(bus.wbs_ack_o), 32'h0);
            @(negedge wb_clk_i);
            checkOutput("no_reack", 32'(bus.wbs_ack_o), 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_sel_i = 4'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;

        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        checkOutput("rst_dat", bus.wbs_dat_o, 32'h0);
        checkOutput("rst_req_valid", 32'(bus.req_valid), 32'h0);
        checkOutput("rst_req_addr", bus.req_addr, 32'h0);
        checkOutput("rst_irq", 32'(bus.err_irq), 32'h0);
        wb_rst_i = 1'b0;

        $display("[TB] read hit");
        applyStimulus(32'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        $display("[TB] write hit with backpressure");
        applyStimulus(32'h3000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 5, 1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        $display("[TB] miss read with stb held past ack");
        applyStimulus(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        $display("[TB] rsp_err on read hit");
        applyStimulus(32'h3000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0000_0055, 1'b1, 1'b0, 1'b0);
        $display("[TB] cyc dropped in WAIT");
        applyStimulus(32'h3000_0008, 1'b0, 32'h0, 4'hF, 0, 2, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h3000_00FC, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        $display("[TB] sel=0 write and miss write");
        applyStimulus(32'h30FF_FFF0, 1'b1, 32'h0000_0001, 4'h0, 0, 0, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h4000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h3000_0020, 1'b1, 32'h0BAD_F00D, 4'hF, 2, 0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] random hits");
        for (int n = 0; n < 6; n++) begin
            logic [31:0] radr;
            radr = BASE | {8'h00, 24'($urandom_range(0, 32'h003F_FFFF)) << 2};
            applyStimulus(radr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] reset mid-transaction");
        @(negedge wb_clk_i);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = 32'h3000_0040;
        bus.wbs_dat_i = 32'hCAFE_0001;
        bus.wbs_sel_i = 4'hF;
        @(negedge wb_clk_i);
        checkOutput("mid_req_valid", 32'(bus.req_valid), 32'h1);
        bus.req_ready = 1'b1;
        @(negedge wb_clk_i);
        bus.req_ready = 1'b0;
        wb_rst_i      = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        checkOutput("mid_rst_req_valid", 32'(bus.req_valid), 32'h0);
        checkOutput("mid_rst_req_wdata", bus.req_wdata, 32'h0);
        checkOutput("mid_rst_req_addr", bus.req_addr, 32'h0);
        wb_rst_i = 1'b0;
        applyStimulus(32'h3000_0044, 1'b0, 32'h0, 4'hF, 0, 0, 32'h4444_5555, 1'b0, 1'b0, 1'b0);

`ifdef RIFT2_WB_TIMEOUT_EN
        begin
            int cyc;
            $display("[TB] timeout with no response");
            @(negedge wb_clk_i);
            bus.wbs_cyc_i = 1'b1;
            bus.wbs_stb_i = 1'b1;
            bus.wbs_we_i  = 1'b0;
            bus.wbs_adr_i = 32'h3000_0080;
            bus.wbs_sel_i = 4'hF;
            expQ.push_back(exp_t'{data: DEAD, err: 1'b1});
            @(negedge wb_clk_i);
            checkOutput("tmo_req_valid", 32'(bus.req_valid), 32'h1);
            bus.req_ready = 1'b1;
            @(negedge wb_clk_i);
            bus.req_ready = 1'b0;
            cyc = 2;
            while (!bus.wbs_ack_o && cyc < 40) begin
                @(negedge wb_clk_i);
                cyc++;
            end
            checkOutput("tmo_latency", 32'(cyc), 32'(TMO_CYC + 1));
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            @(negedge wb_clk_i);
            bus.wbs_cyc_i = 1'b1;
            bus.wbs_stb_i = 1'b1;
            bus.wbs_adr_i = 32'h3000_0084;
            repeat (3) begin
                @(negedge wb_clk_i);
                checkOutput("drop_stall_req", 32'(bus.req_valid), 32'h0);
                checkOutput("drop_stall_ack", 32'(bus.wbs_ack_o), 32'h0);
            end
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = 32'h0BAD_0BAD;
            @(negedge wb_clk_i);
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = 32'h0;
            applyStimulus(32'h3000_0088, 1'b0, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        end
`endif

        repeat (2) @(negedge wb_clk_i);
        checkOutput("sb_empty", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rift2_wb_bridge.md
Name: rift2_wb_bridge

Overview:
- Wishbone classic slave inside the rift2 wrap; directly consumes the Caravel management-SoC Wishbone port (wbs_*).
- Converts each single Wishbone access into one request/response transaction on the core's debug/memory channel.
- Address-window decode, registered single-cycle ack, no pipelining: one transaction in flight.

Parameters:
- ADDR_BASE, 32'h3000_0000, base of the window claimed by the bridge.
- ADDR_MASK, 32'hFF00_0000, address bits compared against ADDR_BASE for a hit.
- TIMEOUT_CYC, 255, cycles in REQ+WAIT before forced completion (only with the optional feature).
- MISS_DATA, 32'h0000_0000, read data returned on a window miss.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered ack, one-cycle pulse.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1.
- req_valid  out  1  request to core channel.
- req_ready  in  1  core accepts request.
- req_we  out  1  write flag.
- req_addr  out  32  address with window bits (ADDR_MASK) cleared.
- req_wdata  out  32  write data.
- req_wstrb  out  4  byte strobes.
- rsp_valid  in  1  response from core. The bridge is always ready in WAIT.
- rsp_rdata  in  32  response data.
- rsp_err  in  1  core-side error.
- err_irq  out  1  one-cycle pulse on rsp_err or timeout.

Behaviour:
Reset (wb_rst_i=1 at a clock edge):
- State goes to IDLE.
- All outputs are 0.
- Timeout counter and drop flag are cleared.
- Reset mid-transaction abandons the transaction with no ack. Downstream is reset by the same signal.

State machine (IDLE, REQ, WAIT, ACK):
- IDLE: on cyc&stb, latch adr/dat/sel/we.
  - Hit (adr&ADDR_MASK == ADDR_BASE&ADDR_MASK): go to REQ.
  - Miss: go to ACK with data MISS_DATA. Writes are discarded.
- REQ: req_valid=1; req_* fields held stable from the latched copy. When req_valid&req_ready, go to WAIT.
- WAIT: when rsp_valid, go to ACK.
  - Read: latch rsp_rdata into the data register.
  - Write: data register is 0.
  - If rsp_err, the data register is 32'hDEAD_BEEF and err_irq pulses in the ACK cycle.
- ACK: wbs_ack_o=1 and wbs_dat_o=data register for exactly one cycle, then IDLE. wbs_dat_o returns to 0 when ack is low.

Latency:
- Hit, with req_ready=1 in the first REQ cycle and rsp_valid in the first WAIT cycle: ack asserts 3 cycles after the cycle in which stb is sampled.
- Miss: ack asserts 1 cycle after stb is sampled.

Boundary conditions:
- The bridge never issues back-to-back acks. The IDLE state after ACK ignores a stb that is still high in that cycle only if it was already acked; in that IDLE cycle a new access needs stb re-sampled.
- cyc dropped in REQ or WAIT: the downstream transaction still completes (no abort), ack is suppressed, and the state returns to IDLE.
- cyc dropped in ACK: the ack pulse still fires (harmless).
- rsp_valid outside WAIT is ignored, except as consumed by the drop flag.
- sel=0 write: forwarded as-is with req_wstrb=0.

Optional Feature:
- Macro: RIFT2_WB_TIMEOUT_EN.
- With it defined:
  - A counter increments every cycle in REQ or WAIT and clears on entry to REQ.
  - On reaching TIMEOUT_CYC the state goes to ACK with data 32'hDEAD_BEEF, and err_irq pulses in the ACK cycle.
  - If the timeout fires in REQ, req_valid deasserts; downstream must tolerate a withdrawn request.
  - If the timeout fires in WAIT, a drop flag is set. The next rsp_valid is swallowed and clears the flag. While the flag is set, IDLE does not accept a new hit access; the access waits with no ack.
- Without it: no counter, no drop flag. REQ/WAIT wait indefinitely, and err_irq pulses only on rsp_err.

Test Plan:
- Read hit: adr=32'h3000_0010, we=0; req_ready=1 at once, rsp_valid one cycle later with rdata=32'h1234_5678 -> req_addr=32'h0000_0010; one ack pulse with dat_o=32'h1234_5678, 3 cycles after stb is sampled.
- Write hit with backpressure: adr=32'h3000_0004, dat=32'hA5A5_A5A5, sel=4'b0011; req_ready low for 5 cycles -> req_valid held with stable fields for 5 cycles, wstrb=4'b0011; single ack after the response.
- Miss: adr=32'h2000_0000 read -> no req_valid; ack 1 cycle later with dat_o=32'h0.
- rsp_err: read hit, response with rsp_err=1 -> dat_o=32'hDEAD_BEEF, err_irq pulse coincident with ack.
- cyc drop: drop cyc in WAIT, then rsp_valid -> no ack, state IDLE; a following read hit completes normally.
- Timeout (RIFT2_WB_TIMEOUT_EN, TIMEOUT_CYC=8): req_ready=1, rsp_valid never -> ack with 32'hDEAD_BEEF after 8 cycles in REQ+WAIT, err_irq=1. A late rsp_valid is dropped, and the next access returns fresh data.
